// File: rtl/rotor_if.sv
// Rotor stage bus: position control, forward/backward letter paths and carry.
interface rotor_if;
    logic       load;
    logic [4:0] load_pos;
    logic       step;
    logic [4:0] fwd_in;
    logic [4:0] bwd_in;
    logic [4:0] fwd_out;
    logic [4:0] bwd_out;
    logic [4:0] pos;
    logic       carry_out;

    modport master (
        output load, load_pos, step, fwd_in, bwd_in,
        input  fwd_out, bwd_out, pos, carry_out
    );

    modport slave (
        input  load, load_pos, step, fwd_in, bwd_in,
        output fwd_out, bwd_out, pos, carry_out
    );
endinterface

// File: rtl/rotor_stage.sv
// Single cipher rotor with wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ.
// Letters are encoded 1..26 = A..Z, 0 means "no letter". Both letter paths
// are registered with one cycle latency and use the position held before
// the edge. The position advances on step, and a carry pulse is produced
// when the rotor moves from Q to R.
module rotor_stage (
    input  logic   clk,
    input  logic   rst,
    rotor_if.slave bus
);

    // Forward wiring, 0-based index to 0-based letter.
    function automatic logic [4:0] wire_fwd(input logic [4:0] idx);
        logic [4:0] w;
        case (idx)
            5'd0:    w = 5'd4;
            5'd1:    w = 5'd10;
            5'd2:    w = 5'd12;
            5'd3:    w = 5'd5;
            5'd4:    w = 5'd11;
            5'd5:    w = 5'd6;
            5'd6:    w = 5'd3;
            5'd7:    w = 5'd16;
            5'd8:    w = 5'd21;
            5'd9:    w = 5'd25;
            5'd10:   w = 5'd13;
            5'd11:   w = 5'd19;
            5'd12:   w = 5'd14;
            5'd13:   w = 5'd22;
            5'd14:   w = 5'd24;
            5'd15:   w = 5'd7;
            5'd16:   w = 5'd23;
            5'd17:   w = 5'd20;
            5'd18:   w = 5'd18;
            5'd19:   w = 5'd15;
            5'd20:   w = 5'd0;
            5'd21:   w = 5'd8;
            5'd22:   w = 5'd1;
            5'd23:   w = 5'd17;
            5'd24:   w = 5'd2;
            5'd25:   w = 5'd9;
            default: w = 5'd0;
        endcase
        return w;
    endfunction

    // Inverse wiring, 0-based letter back to 0-based index.
    function automatic logic [4:0] wire_bwd(input logic [4:0] idx);
        logic [4:0] w;
        case (idx)
            5'd0:    w = 5'd20;
            5'd1:    w = 5'd22;
            5'd2:    w = 5'd24;
            5'd3:    w = 5'd6;
            5'd4:    w = 5'd0;
            5'd5:    w = 5'd3;
            5'd6:    w = 5'd5;
            5'd7:    w = 5'd15;
            5'd8:    w = 5'd21;
            5'd9:    w = 5'd25;
            5'd10:   w = 5'd1;
            5'd11:   w = 5'd4;
            5'd12:   w = 5'd2;
            5'd13:   w = 5'd10;
            5'd14:   w = 5'd12;
            5'd15:   w = 5'd19;
            5'd16:   w = 5'd7;
            5'd17:   w = 5'd23;
            5'd18:   w = 5'd18;
            5'd19:   w = 5'd11;
            5'd20:   w = 5'd17;
            5'd21:   w = 5'd8;
            5'd22:   w = 5'd13;
            5'd23:   w = 5'd16;
            5'd24:   w = 5'd14;
            5'd25:   w = 5'd9;
            default: w = 5'd0;
        endcase
        return w;
    endfunction

    // Map one letter through the rotor at offset p (0-based position).
    // Invalid letters map to 0. bwd selects the inverse wiring.
    function automatic logic [4:0] map_letter(input logic [4:0] letter,
                                              input logic [4:0] p,
                                              input logic       bwd);
        logic [5:0] sum;
        logic [4:0] w;
        logic [4:0] r;
        if ((letter >= 5'd1) && (letter <= 5'd26)) begin
            sum = {1'b0, letter - 5'd1} + {1'b0, p};
            if (sum >= 6'd26) begin
                sum = sum - 6'd26;
            end else begin
                sum = sum;
            end
            if (bwd) begin
                w = wire_bwd(sum[4:0]);
            end else begin
                w = wire_fwd(sum[4:0]);
            end
            if (w >= p) begin
                r = w - p;
            end else begin
                r = w + 5'd26 - p;
            end
            return r + 5'd1;
        end else begin
            return 5'd0;
        end
    endfunction

    logic [4:0] pos_r;
    logic [4:0] fwd_r;
    logic [4:0] bwd_r;
    logic       carry_r;

    logic [4:0] offset_s;
    logic [4:0] pos_next_s;
    logic [4:0] fwd_next_s;
    logic [4:0] bwd_next_s;
    logic       carry_next_s;

    // Next position, letter maps and carry, all from the pre-edge position.
    always_comb begin
        offset_s     = pos_r - 5'd1;
        fwd_next_s   = map_letter(bus.fwd_in, offset_s, 1'b0);
        bwd_next_s   = map_letter(bus.bwd_in, offset_s, 1'b1);
        carry_next_s = 1'b0;
        if (bus.load) begin
            if ((bus.load_pos >= 5'd1) && (bus.load_pos <= 5'd26)) begin
                pos_next_s = bus.load_pos;
            end else begin
                pos_next_s = 5'd1;
            end
        end else if (bus.step) begin
            if (pos_r >= 5'd26) begin
                pos_next_s = 5'd1;
            end else begin
                pos_next_s = pos_r + 5'd1;
            end
            carry_next_s = (pos_r == 5'd17);
        end else begin
            pos_next_s = pos_r;
        end
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_r   <= 5'd1;
            fwd_r   <= 5'd0;
            bwd_r   <= 5'd0;
            carry_r <= 1'b0;
        end else begin
            pos_r   <= pos_next_s;
            fwd_r   <= fwd_next_s;
            bwd_r   <= bwd_next_s;
            carry_r <= carry_next_s;
        end
    end

    assign bus.pos       = pos_r;
    assign bus.fwd_out   = fwd_r;
    assign bus.bwd_out   = bwd_r;
    assign bus.carry_out = carry_r;

endmodule

// File: tb/tb_rotor_stage.sv
// Self-checking bench for rotor_stage: reset checks, a directed vector
// table, a randomised run against a reference model, and reset corners.
// Letter-path expectations flow through a scoreboard queue.
module tb_rotor_stage;

    logic clk;
    logic rst;
    logic clk_en;
    rotor_if bus ();

    rotor_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock once enabled.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic       load;
        logic [4:0] load_pos;
        logic       step;
        logic [4:0] fwd_in;
        logic [4:0] bwd_in;
        logic [4:0] exp_fwd;
        logic [4:0] exp_bwd;
        logic [4:0] exp_pos;
        logic       exp_carry;
    } vec_t;

    typedef struct {
        logic [4:0] f;
        logic [4:0] b;
    } exp_t;

    exp_t sbq[$];
    int   tests;
    int   fails;
    int   m_pos;
    int   m_carry;
    string wiring = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference letter map straight from the wiring string.
    function automatic int model_map(input int letter, input int p1, input bit bwd);
        int x, p, s, w;
        if (letter < 1 || letter > 26) return 0;
        x = letter - 1;
        p = p1 - 1;
        s = (x + p) % 26;
        w = 0;
        if (!bwd) begin
            w = int'(wiring[s]) - 65;
        end else begin
            for (int j = 0; j < 26; j++)
                if (int'(wiring[j]) - 65 == s) w = j;
        end
        return ((w - p + 26) % 26) + 1;
    endfunction

    task automatic drive(input logic ld, input logic [4:0] lp, input logic st,
                         input logic [4:0] fi, input logic [4:0] bi);
        bus.load     = ld;
        bus.load_pos = lp;
        bus.step     = st;
        bus.fwd_in   = fi;
        bus.bwd_in   = bi;
    endtask

    // Pop one scoreboard entry and compare the letter outputs.
    task automatic sb_check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            check({tag, "_fwd"}, int'(bus.fwd_out), int'(e.f));
            check({tag, "_bwd"}, int'(bus.bwd_out), int'(e.b));
        end
    endtask

    vec_t vt[17];

    initial begin
        exp_t e;
        int ld, lp, st, fi, bi, ep, ec;
        tests  = 0;
        fails  = 0;
        clk_en = 1'b0;
        rst    = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 5'd3, 5'd3);

        // Directed vectors; each entry is one clock edge.
        vt[0]  = '{1'b0, 5'd0,  1'b0, 5'd1,  5'd5,  5'd5,  5'd1,  5'd1,  1'b0};
        vt[1]  = '{1'b0, 5'd0,  1'b0, 5'd26, 5'd0,  5'd10, 5'd0,  5'd1,  1'b0};
        vt[2]  = '{1'b1, 5'd2,  1'b0, 5'd0,  5'd27, 5'd0,  5'd0,  5'd2,  1'b0};
        vt[3]  = '{1'b0, 5'd0,  1'b0, 5'd1,  5'd10, 5'd10, 5'd1,  5'd2,  1'b0};
        vt[4]  = '{1'b1, 5'd17, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd17, 1'b0};
        vt[5]  = '{1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  5'd18, 1'b1};
        vt[6]  = '{1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  5'd19, 1'b0};
        vt[7]  = '{1'b1, 5'd26, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd26, 1'b0};
        vt[8]  = '{1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  5'd1,  1'b0};
        vt[9]  = '{1'b1, 5'd5,  1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  5'd5,  1'b0};
        vt[10] = '{1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd1,  1'b0};
        vt[11] = '{1'b1, 5'd18, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd18, 1'b0};
        vt[12] = '{1'b1, 5'd31, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd1,  1'b0};
        vt[13] = '{1'b1, 5'd17, 1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  5'd17, 1'b0};
        vt[14] = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd17, 1'b0};
        vt[15] = '{1'b0, 5'd0,  1'b1, 5'd1,  5'd1,  5'd8,  5'd18, 5'd18, 1'b1};
        vt[16] = '{1'b0, 5'd0,  1'b0, 5'd1,  5'd0,  5'd4,  5'd0,  5'd18, 1'b0};

        // Reset with no clock edges at all.
        #3;
        check("rst_pos",   int'(bus.pos),       1);
        check("rst_fwd",   int'(bus.fwd_out),   0);
        check("rst_bwd",   int'(bus.bwd_out),   0);
        check("rst_carry", int'(bus.carry_out), 0);

        // Clock running under reset with load/step asserted: pos stays 1.
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ld_pos", int'(bus.pos), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].load, vt[i].load_pos, vt[i].step, vt[i].fwd_in, vt[i].bwd_in);
            e.f = vt[i].exp_fwd;
            e.b = vt[i].exp_bwd;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            sb_check($sformatf("vec%0d", i));
            check($sformatf("vec%0d_pos", i),   int'(bus.pos),       int'(vt[i].exp_pos));
            check($sformatf("vec%0d_carry", i), int'(bus.carry_out), int'(vt[i].exp_carry));
            @(negedge clk);
        end

        // Randomised run against the reference model.
        m_pos = 18;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 9) == 0) ? 1 : 0;
            st = ($urandom_range(0, 2) == 0) ? 1 : 0;
            lp = $urandom_range(0, 31);
            fi = $urandom_range(0, 31);
            bi = $urandom_range(0, 31);
            drive(ld[0], lp[4:0], st[0], fi[4:0], bi[4:0]);
            e.f = 5'(model_map(fi, m_pos, 1'b0));
            e.b = 5'(model_map(bi, m_pos, 1'b1));
            sbq.push_back(e);
            ec = 0;
            if (ld != 0) begin
                ep = (lp >= 1 && lp <= 26) ? lp : 1;
            end else if (st != 0) begin
                ep = (m_pos == 26) ? 1 : m_pos + 1;
                ec = (m_pos == 17) ? 1 : 0;
            end else begin
                ep = m_pos;
            end
            m_pos = ep;
            @(posedge clk);
            #1;
            sb_check($sformatf("rnd%0d", i));
            check($sformatf("rnd%0d_pos", i),   int'(bus.pos),       ep);
            check($sformatf("rnd%0d_carry", i), int'(bus.carry_out), ec);
            @(negedge clk);
        end

        // Reset coincident with a notch step: no carry, pos back to 1.
        drive(1'b1, 5'd17, 1'b0, 5'd0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 1'b1, 5'd4, 5'd4);
        rst = 1'b1;
        #1;
        check("arst_pos",   int'(bus.pos),       1);
        check("arst_fwd",   int'(bus.fwd_out),   0);
        check("arst_carry", int'(bus.carry_out), 0);
        @(posedge clk);
        #1;
        check("arst_edge_pos",   int'(bus.pos),       1);
        check("arst_edge_carry", int'(bus.carry_out), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b1, 5'd1, 5'd0);
        @(posedge clk);
        #1;
        check("post_rst_pos",   int'(bus.pos),       2);
        check("post_rst_fwd",   int'(bus.fwd_out),   5);
        check("post_rst_carry", int'(bus.carry_out), 0);
        @(negedge clk);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
